axist_rx_pkt_chkr: RTL and testbench

AXIST_RX_PKT_CHKR -- requirements
Module: axist_rx_pkt_chkr

---
 rtl/axist_rx_pkt_chkr.sv | 136 +++++++++++++
 tb/tb_axist_rx_pkt_chkr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axist_rx_pkt_chkr.sv
// AXI-ST receive packet checker: accepts one run of beats, compares them against an
// incrementing or LFSR pattern, and reports the first/last beats, error count and pass/done status.
module axist_rx_pkt_chkr #(
   parameter int          DWIDTH    = 64,
   parameter logic [63:0] LFSR_SEED = 64'hA5A5_5A5A_C3C3_3C3C
) (
   input  logic              i_wr_clk,
   input  logic              i_wr_rst,
   input  logic              i_start,
   input  logic              i_pat_random,
   input  logic [7:0]        i_pkt_cnt,
   input  logic              i_rx_online,
   input  logic              i_tvalid,
   input  logic [DWIDTH-1:0] i_tdata,
   input  logic              i_tlast,
   output logic              o_tready,
   output logic [DWIDTH-1:0] o_first_data,
   output logic [DWIDTH-1:0] o_last_data,
   output logic [3:0]        o_status,
   output logic [15:0]       o_err_cnt,
   output logic [8:0]        o_beat_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic                run_dec;
   logic                done_dec;

   logic [7:0]          cnt_reg;
   logic                random_reg;
   logic [63:0]         lfsr_reg;
   logic [8:0]          beat_cnt_reg;
   logic [15:0]         err_cnt_reg;
   logic [DWIDTH-1:0]   first_data_reg;
   logic [DWIDTH-1:0]   last_data_reg;
   logic                aligned_reg;

   logic                start_ok;
   logic                beat_acc;
   logic                is_last;
   logic                lfsr_fb;
   logic [63:0]         lfsr_next;
   logic [DWIDTH-1:0]   exp_inc;
   logic [DWIDTH-1:0]   exp_data;
   logic                mismatch;

   // Incrementing pattern replicates the zero-extended beat index in both 32-bit halves.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_inc_half
         assign exp_inc[gi*32 +: 32] = {23'd0, beat_cnt_reg};
      end
   endgenerate

   // Taps for x^64+x^63+x^61+x^60+1, shifted left with feedback into bit 0.
   assign lfsr_fb   = lfsr_reg[63] ^ lfsr_reg[62] ^ lfsr_reg[60] ^ lfsr_reg[59];
   assign lfsr_next = {lfsr_reg[62:0], lfsr_fb};

   assign exp_data = random_reg ? lfsr_reg : exp_inc;
   assign start_ok = i_start & ~run_dec;
   assign beat_acc = i_tvalid & o_tready;
   assign is_last  = (beat_cnt_reg[7:0] == cnt_reg);
   assign mismatch = (i_tdata != exp_data) | (i_tlast != is_last);

   always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
      if (i_wr_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_start) state_next = RUN;
         RUN:     if (beat_acc && is_last) state_next = DONE;
         DONE:    if (i_start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      run_dec  = (state_reg == RUN);
      done_dec = (state_reg == DONE);
      o_tready = run_dec & i_rx_online;
   end

   always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
      if (i_wr_rst) begin
         cnt_reg        <= '0;
         random_reg     <= 1'b0;
         lfsr_reg       <= LFSR_SEED;
         beat_cnt_reg   <= '0;
         err_cnt_reg    <= '0;
         first_data_reg <= '0;
         last_data_reg  <= '0;
         aligned_reg    <= 1'b0;
      end else begin
         aligned_reg <= i_rx_online;
         if (start_ok) begin
            cnt_reg        <= i_pkt_cnt;
            random_reg     <= i_pat_random;
            lfsr_reg       <= LFSR_SEED;
            beat_cnt_reg   <= '0;
            err_cnt_reg    <= '0;
            first_data_reg <= '0;
            last_data_reg  <= '0;
         end else if (beat_acc) begin
            lfsr_reg      <= lfsr_next;
            beat_cnt_reg  <= beat_cnt_reg + 9'd1;
            last_data_reg <= i_tdata;
            if (beat_cnt_reg == 9'd0) begin
               first_data_reg <= i_tdata;
            end
            // Saturate rather than wrap so a long bad run never reads back as clean.
            if (mismatch && (err_cnt_reg != 16'hFFFF)) begin
               err_cnt_reg <= err_cnt_reg + 16'd1;
            end
         end
      end
   end

   assign o_first_data = first_data_reg;
   assign o_last_data  = last_data_reg;
   assign o_beat_cnt   = beat_cnt_reg;
   assign o_err_cnt    = err_cnt_reg;
   assign o_status     = {aligned_reg, 1'b0, done_dec, done_dec & (err_cnt_reg == 16'd0)};

endmodule

// File: tb/tb_axist_rx_pkt_chkr.sv
// Bench for axist_rx_pkt_chkr: directed runs checked every cycle against a beat-level
// model of the checker, plus literal expectations for the documented scenarios.
module tb_axist_rx_pkt_chkr;

   localparam logic [63:0] SEED = 64'hA5A5_5A5A_C3C3_3C3C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_pat_random = 1'b0;
   logic [7:0]  i_pkt_cnt = 8'd0;
   logic        i_rx_online = 1'b1;
   logic        i_tvalid = 1'b0;
   logic [63:0] i_tdata = 64'd0;
   logic        i_tlast = 1'b0;
   logic        o_tready;
   logic [63:0] o_first_data;
   logic [63:0] o_last_data;
   logic [3:0]  o_status;
   logic [15:0] o_err_cnt;
   logic [8:0]  o_beat_cnt;

   int checks = 0;
   int errors = 0;

   axist_rx_pkt_chkr #(.DWIDTH(64), .LFSR_SEED(SEED)) dut (
      .i_wr_clk     (clk),
      .i_wr_rst     (rst),
      .i_start      (i_start),
      .i_pat_random (i_pat_random),
      .i_pkt_cnt    (i_pkt_cnt),
      .i_rx_online  (i_rx_online),
      .i_tvalid     (i_tvalid),
      .i_tdata      (i_tdata),
      .i_tlast      (i_tlast),
      .o_tready     (o_tready),
      .o_first_data (o_first_data),
      .o_last_data  (o_last_data),
      .o_status     (o_status),
      .o_err_cnt    (o_err_cnt),
      .o_beat_cnt   (o_beat_cnt)
   );

   initial forever #5 clk = ~clk;

   // Pattern table: entry k is the expected random-mode data for beat k.
   logic [63:0] lfsr_tab [0:256];

   function automatic logic [63:0] lfsr_step(input logic [63:0] v);
      return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
   endfunction

   function automatic logic [63:0] pat(input bit rnd, input int k);
      logic [31:0] kk;
      kk = 32'(k);
      return rnd ? lfsr_tab[k] : {kk, kk};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 40) $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Beat-level model of one checker run.
   bit          m_running = 0;
   bit          m_done = 0;
   bit          m_rand = 0;
   bit          m_aligned = 0;
   int          m_cnt = 0;
   int          m_k = 0;
   int          m_err = 0;
   logic [63:0] m_first = '0;
   logic [63:0] m_last = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_running = 0; m_done = 0; m_rand = 0; m_aligned = 0;
         m_cnt = 0; m_k = 0; m_err = 0; m_first = '0; m_last = '0;
      end else begin
         if (!m_running && i_start) begin
            m_running = 1; m_done = 0; m_rand = i_pat_random; m_cnt = int'(i_pkt_cnt);
            m_k = 0; m_err = 0; m_first = '0; m_last = '0;
         end else if (m_running && i_rx_online && i_tvalid) begin
            if ((i_tdata !== pat(m_rand, m_k)) || (i_tlast !== (m_k == m_cnt)))
               m_err = (m_err < 65535) ? m_err + 1 : m_err;
            if (m_k == 0) m_first = i_tdata;
            m_last = i_tdata;
            if (m_k == m_cnt) begin
               m_running = 0; m_done = 1;
            end
            m_k++;
         end
         m_aligned = i_rx_online;
      end
   end

   always @(negedge clk) begin
      chk("tready",   64'(o_tready),     64'(m_running && i_rx_online));
      chk("beat_cnt", 64'(o_beat_cnt),   64'(m_k));
      chk("err_cnt",  64'(o_err_cnt),    64'(m_err));
      chk("first",    o_first_data,      m_first);
      chk("last",     o_last_data,       m_last);
      chk("status",   64'(o_status),     64'({m_aligned, 1'b0, m_done, m_done && (m_err == 0)}));
   end

   // Entry and exit of these tasks is one time unit after a rising edge.
   task automatic pulse_start(input bit rnd, input logic [7:0] cnt);
      i_start = 1'b1; i_pat_random = rnd; i_pkt_cnt = cnt;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_beats(input bit rnd, input int first_k, input int n, input int last_k,
                             input int last_extra, input int corrupt_k, input bit toggle,
                             input int budget);
      int j;
      int cyc;
      bit acc;
      j = first_k;
      cyc = 0;
      while ((j < first_k + n) && (cyc < budget)) begin
         i_tvalid = 1'b1;
         i_tdata  = pat(rnd, j) ^ ((j == corrupt_k) ? 64'h1 : 64'h0);
         i_tlast  = (j == last_k) || (j == last_extra);
         if (toggle) i_rx_online = ((cyc / 3) % 2 == 0);
         @(negedge clk);
         acc = i_tvalid && o_tready;
         @(posedge clk); #1;
         if (acc) j++;
         cyc++;
      end
      i_tvalid = 1'b0; i_tlast = 1'b0; i_rx_online = 1'b1;
      chk("beats_sent_in_budget", 64'(j), 64'(first_k + n));
   endtask

   task automatic report(input int run);
      $display("run %0d: beats=%0d err=%0d status=%b first=%h last=%h",
               run, o_beat_cnt, o_err_cnt, o_status, o_first_data, o_last_data);
   endtask

   initial begin
      lfsr_tab[0] = SEED;
      for (int i = 1; i <= 256; i++) lfsr_tab[i] = lfsr_step(lfsr_tab[i-1]);
      chk("lfsr_step1_literal", lfsr_tab[1], 64'h4B4A_B4B5_8786_7879);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // Beats offered before any start must be ignored.
      i_tvalid = 1'b1; i_tdata = 64'd0;
      repeat (3) @(posedge clk);
      #1 i_tvalid = 1'b0;
      @(negedge clk);
      chk("idle_no_accept", 64'(o_beat_cnt), 64'd0);
      @(posedge clk); #1;

      // Run 1: incrementing, four clean beats.
      pulse_start(1'b0, 8'd3);
      send_beats(1'b0, 0, 4, 3, -1, -1, 1'b0, 50);
      @(negedge clk);
      chk("r1_beat_cnt", 64'(o_beat_cnt), 64'd4);
      chk("r1_status",   64'(o_status),   64'(4'b1011));
      chk("r1_first",    o_first_data,    64'd0);
      chk("r1_last",     o_last_data,     64'h0000_0003_0000_0003);
      report(1);
      @(posedge clk); #1;

      // Run 2: random, 256 beats.
      pulse_start(1'b1, 8'hFF);
      send_beats(1'b1, 0, 256, 255, -1, -1, 1'b0, 400);
      @(negedge clk);
      chk("r2_tready_low", 64'(o_tready),   64'd0);
      chk("r2_status",     64'(o_status),   64'(4'b1011));
      chk("r2_err",        64'(o_err_cnt),  64'd0);
      chk("r2_first",      o_first_data,    64'hA5A5_5A5A_C3C3_3C3C);
      chk("r2_beat_cnt",   64'(o_beat_cnt), 64'd256);
      report(2);
      @(posedge clk); #1;

      // Run 3: beat 2 corrupted, spurious tlast on beat 1.
      pulse_start(1'b0, 8'd3);
      send_beats(1'b0, 0, 4, 3, 1, 2, 1'b0, 50);
      @(negedge clk);
      chk("r3_err",    64'(o_err_cnt), 64'd2);
      chk("r3_status", 64'(o_status),  64'(4'b1010));
      report(3);
      @(posedge clk); #1;

      // Run 4: link toggles every three cycles with valid held high.
      pulse_start(1'b0, 8'd15);
      send_beats(1'b0, 0, 16, 15, -1, -1, 1'b1, 200);
      @(negedge clk);
      chk("r4_beat_cnt", 64'(o_beat_cnt), 64'd16);
      chk("r4_status",   64'(o_status),   64'(4'b1011));
      report(4);
      @(posedge clk); #1;

      // Run 5: reset mid-run, then a short two-beat run.
      pulse_start(1'b0, 8'd15);
      send_beats(1'b0, 0, 6, 15, -1, -1, 1'b0, 50);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_tready", 64'(o_tready),   64'd0);
      chk("rst_beat",   64'(o_beat_cnt), 64'd0);
      chk("rst_err",    64'(o_err_cnt),  64'd0);
      chk("rst_first",  o_first_data,    64'd0);
      chk("rst_last",   o_last_data,     64'd0);
      chk("rst_status", 64'(o_status),   64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      i_tvalid = 1'b1; i_tdata = 64'd0;
      repeat (4) @(posedge clk);
      #1 i_tvalid = 1'b0;
      @(negedge clk);
      chk("post_rst_no_accept", 64'(o_beat_cnt), 64'd0);
      @(posedge clk); #1;
      pulse_start(1'b0, 8'd1);
      send_beats(1'b0, 0, 2, 1, -1, -1, 1'b0, 50);
      @(negedge clk);
      chk("r5_beat_cnt", 64'(o_beat_cnt), 64'd2);
      chk("r5_status",   64'(o_status),   64'(4'b1011));
      report(5);
      @(posedge clk); #1;

      // Run 6: start mid-run is ignored; start after done restarts cleanly.
      pulse_start(1'b0, 8'd3);
      send_beats(1'b0, 0, 2, 3, -1, -1, 1'b0, 50);
      pulse_start(1'b1, 8'd7);
      send_beats(1'b0, 2, 2, 3, -1, -1, 1'b0, 50);
      @(negedge clk);
      chk("r6_beat_cnt", 64'(o_beat_cnt), 64'd4);
      chk("r6_status",   64'(o_status),   64'(4'b1011));
      report(6);
      @(posedge clk); #1;
      pulse_start(1'b0, 8'd3);
      @(negedge clk);
      chk("r7_clr_beat",   64'(o_beat_cnt), 64'd0);
      chk("r7_clr_first",  o_first_data,    64'd0);
      chk("r7_clr_last",   o_last_data,     64'd0);
      chk("r7_clr_status", 64'(o_status),   64'(4'b1000));
      @(posedge clk); #1;
      send_beats(1'b0, 0, 4, 3, -1, -1, 1'b0, 50);
      @(negedge clk);
      chk("r7_status", 64'(o_status), 64'(4'b1011));
      report(7);

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
